// File: rtl/mc_control_pkg.sv
// Shared definitions for the multi-cycle main controller: state codes,
// opcode/funct constants, ALU opcodes common with the ALU, datapath select
// codes and the decoded instruction-class bundle.
package mc_control_pkg;

    // Controller states; encodings 5..7 are illegal and recover to IF.
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_DT  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    // Primary opcodes (Instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (Instr[5:0])
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;  // rotr when Instr[21]=1
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MOVZ  = 6'h0A;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;

    // ALU opcodes shared with the ALU
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_MOVZ = 4'b0111;
    localparam logic [3:0] ALU_ROTR = 4'b1000;

    // Destination register select
    localparam logic [1:0] RD_RT    = 2'd0;
    localparam logic [1:0] RD_RD    = 2'd1;
    localparam logic [1:0] RD_RA    = 2'd2;

    // Immediate extension select
    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_HI   = 2'd2;

    // Write-back source select
    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_PC4   = 2'd2;

    // Next-PC source select
    localparam logic [1:0] PC_SEQ   = 2'd0;
    localparam logic [1:0] PC_BR    = 2'd1;
    localparam logic [1:0] PC_JMP   = 2'd2;
    localparam logic [1:0] PC_RS    = 2'd3;

    // One-hot instruction class plus the EXE ALU opcode.
    // lui is kept apart from ori because it selects a different extension.
    typedef struct packed {
        logic       rcal;
        logic       ical;
        logic       lui;
        logic       load;
        logic       store;
        logic       branch;
        logic       jump;
        logic       link;
        logic       jreg;
        logic       movz_i;
        logic       nop;
        logic [3:0] aluctr;
    } dec_t;

endpackage

// File: rtl/mc_control_decode.sv
// Combinational instruction decoder: maps the IR to instruction-class flags
// and the ALU opcode used from EXE onward.
module mc_decode
    import mc_control_pkg::*;
(
    input  logic [31:0] i_instr,
    output dec_t        o_dec
);

    logic [5:0] w_op;
    logic [5:0] w_fn;

    assign w_op = i_instr[31:26];
    assign w_fn = i_instr[5:0];

    // Classify the instruction; anything unrecognised falls to nop.
    always_comb begin
        o_dec        = '0;
        o_dec.aluctr = ALU_ADD;
        case (w_op)
            OP_RTYPE: begin
                o_dec.rcal = 1'b1;
                case (w_fn)
                    FN_ADDU: o_dec.aluctr = ALU_ADD;
                    FN_SUBU: o_dec.aluctr = ALU_SUB;
                    FN_AND:  o_dec.aluctr = ALU_AND;
                    FN_OR:   o_dec.aluctr = ALU_OR;
                    FN_XOR:  o_dec.aluctr = ALU_XOR;
                    FN_SLL:  o_dec.aluctr = ALU_SLL;
                    FN_SRL:  o_dec.aluctr = i_instr[21] ? ALU_ROTR : ALU_SRL;
                    FN_MOVZ: begin
                        o_dec.aluctr = ALU_MOVZ;
                        o_dec.movz_i = 1'b1;
                    end
                    FN_JR: begin
                        o_dec.rcal = 1'b0;
                        o_dec.jreg = 1'b1;
                    end
                    default: begin
                        o_dec.rcal = 1'b0;
                        o_dec.nop  = 1'b1;
                    end
                endcase
            end
            OP_ORI: begin
                o_dec.ical   = 1'b1;
                o_dec.aluctr = ALU_OR;
            end
            OP_LUI: begin
                o_dec.ical   = 1'b1;
                o_dec.lui    = 1'b1;
                o_dec.aluctr = ALU_ADD;
            end
            OP_LW:  o_dec.load  = 1'b1;
            OP_SW:  o_dec.store = 1'b1;
            OP_BEQ: begin
                o_dec.branch = 1'b1;
                o_dec.aluctr = ALU_SUB;
            end
            OP_J:   o_dec.jump = 1'b1;
            OP_JAL: begin
                o_dec.jump = 1'b1;
                o_dec.link = 1'b1;
            end
            default: o_dec.nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle main controller: state register plus per-state datapath
// control (ALU opcode, mux selects, write enables).
module mc_control
    import mc_control_pkg::*;
#(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        movz,
    input  logic        cmp_eq,
    output logic [3:0]  ALUCtr,
    output logic        PCWr,
    output logic        IRWr,
    output logic        RegWr,
    output logic        MemWr,
    output logic [1:0]  RegDst,
    output logic        ALUSrc,
    output logic [1:0]  ExtOp,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  PCSrc,
    output logic [2:0]  state
);

    state_t r_state;
    state_t w_next;
    dec_t   w_dec;
    logic   w_pcwr;
    logic   w_irwr;
    logic   w_regwr;
    logic   w_memwr;
    logic   w_imm;

    mc_decode u_decode (
        .i_instr (Instr),
        .o_dec   (w_dec)
    );

    assign state = r_state;
    assign w_imm = w_dec.ical | w_dec.load | w_dec.store;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= state_t'(RESET_STATE);
        else        r_state <= w_next;
    end

    // Per-state outputs and next state; ALU controls persist through MEM/WB.
    always_comb begin
        w_next   = S_IF;
        w_pcwr   = 1'b0;
        w_irwr   = 1'b0;
        w_regwr  = 1'b0;
        w_memwr  = 1'b0;
        ALUCtr   = ALU_ADD;
        RegDst   = RD_RT;
        ALUSrc   = 1'b0;
        ExtOp    = EXT_ZERO;
        MemtoReg = WB_ALU;
        PCSrc    = PC_SEQ;
        case (r_state)
            S_IF: begin
                w_irwr = 1'b1;
                w_pcwr = 1'b1;
                w_next = S_DT;
            end
            S_DT: begin
                if (w_dec.jump) begin
                    w_pcwr = 1'b1;
                    PCSrc  = PC_JMP;
                    if (w_dec.link) begin
                        w_regwr  = 1'b1;
                        RegDst   = RD_RA;
                        MemtoReg = WB_PC4;
                    end
                end else if (w_dec.jreg) begin
                    w_pcwr = 1'b1;
                    PCSrc  = PC_RS;
                end else if (!w_dec.nop) begin
                    w_next = S_EXE;
                end
            end
            S_EXE, S_MEM, S_WB: begin
                ALUCtr = w_dec.aluctr;
                ALUSrc = w_imm;
                if (w_dec.lui)                        ExtOp = EXT_HI;
                else if (w_dec.load || w_dec.store)   ExtOp = EXT_SIGN;
                else                                  ExtOp = EXT_ZERO;
                if (r_state == S_EXE) begin
                    if (w_dec.branch) begin
                        w_pcwr = cmp_eq;
                        PCSrc  = PC_BR;
                    end else if (w_dec.load || w_dec.store) begin
                        w_next = S_MEM;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (r_state == S_MEM) begin
                    if (w_dec.store) w_memwr = 1'b1;
                    if (w_dec.load)  w_next  = S_WB;
                end else begin
                    w_regwr  = w_dec.movz_i ? movz : 1'b1;
                    RegDst   = w_dec.rcal ? RD_RD : RD_RT;
                    MemtoReg = w_dec.load ? WB_MEM : WB_ALU;
                end
            end
            default: w_next = S_IF;
        endcase
    end

    // Write enables are gated off while reset is held.
    always_comb begin
        PCWr  = w_pcwr  & reset;
        IRWr  = w_irwr  & reset;
        RegWr = w_regwr & reset;
        MemWr = w_memwr & reset;
    end

endmodule

// File: tb/tb_mc_control.sv
// Directed-vector bench for mc_control with hand-computed expectations.
module tb_mc_control;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic        movz;
    logic        cmp_eq;
    logic [3:0]  ALUCtr;
    logic        PCWr;
    logic        IRWr;
    logic        RegWr;
    logic        MemWr;
    logic [1:0]  RegDst;
    logic        ALUSrc;
    logic [1:0]  ExtOp;
    logic [1:0]  MemtoReg;
    logic [1:0]  PCSrc;
    logic [2:0]  state;

    int unsigned n_vec;
    int unsigned n_bad;

    mc_control #(.RESET_STATE(3'd0)) dut (
        .clk      (clk),
        .reset    (reset),
        .Instr    (Instr),
        .movz     (movz),
        .cmp_eq   (cmp_eq),
        .ALUCtr   (ALUCtr),
        .PCWr     (PCWr),
        .IRWr     (IRWr),
        .RegWr    (RegWr),
        .MemWr    (MemWr),
        .RegDst   (RegDst),
        .ALUSrc   (ALUSrc),
        .ExtOp    (ExtOp),
        .MemtoReg (MemtoReg),
        .PCSrc    (PCSrc),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle past the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        reset  = 1'b0;
        Instr  = 32'h00000000;
        movz   = 1'b0;
        cmp_eq = 1'b0;

        // Reset held for two edges
        tick();
        tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_regwr", 32'(RegWr), 0);
        chk("rst_memwr", 32'(MemWr), 0);
        chk("rst_irwr_forced", 32'(IRWr), 0);
        chk("rst_pcwr_forced", 32'(PCWr), 0);
        reset = 1'b1;
        #1;
        chk("if_irwr", 32'(IRWr), 1);
        chk("if_pcwr", 32'(PCWr), 1);
        chk("if_pcsrc", 32'(PCSrc), 0);

        // addu $3,$1,$2
        Instr = 32'h00221821;
        tick(); chk("addu_dt", 32'(state), 1);
        tick(); chk("addu_exe", 32'(state), 2);
        chk("addu_aluctr", 32'(ALUCtr), 4'b0000);
        chk("addu_alusrc", 32'(ALUSrc), 0);
        tick(); chk("addu_wb", 32'(state), 4);
        chk("addu_regwr", 32'(RegWr), 1);
        chk("addu_regdst", 32'(RegDst), 1);
        chk("addu_memtoreg", 32'(MemtoReg), 0);
        tick(); chk("addu_if", 32'(state), 0);

        // lw $2,4($1)
        Instr = 32'h8C220004;
        tick(); chk("lw_dt", 32'(state), 1);
        tick(); chk("lw_exe", 32'(state), 2);
        chk("lw_extop", 32'(ExtOp), 1);
        chk("lw_alusrc", 32'(ALUSrc), 1);
        tick(); chk("lw_mem", 32'(state), 3);
        chk("lw_mem_memwr", 32'(MemWr), 0);
        chk("lw_mem_extop_held", 32'(ExtOp), 1);
        tick(); chk("lw_wb", 32'(state), 4);
        chk("lw_memtoreg", 32'(MemtoReg), 1);
        chk("lw_regdst", 32'(RegDst), 0);
        chk("lw_regwr", 32'(RegWr), 1);
        tick(); chk("lw_if", 32'(state), 0);

        // beq taken
        Instr = 32'h10220003;
        cmp_eq = 1'b1;
        tick(); tick();
        chk("beq_exe", 32'(state), 2);
        chk("beq_t_pcwr", 32'(PCWr), 1);
        chk("beq_pcsrc", 32'(PCSrc), 1);
        chk("beq_aluctr", 32'(ALUCtr), 4'b0001);
        tick(); chk("beq_if", 32'(state), 0);
        // beq not taken
        cmp_eq = 1'b0;
        tick(); tick();
        chk("beq_nt_pcwr", 32'(PCWr), 0);
        tick(); chk("beq_nt_if", 32'(state), 0);

        // movz with movz flag low, then raised live in WB
        Instr = 32'h0022180A;
        movz = 1'b0;
        tick(); tick();
        chk("movz_aluctr", 32'(ALUCtr), 4'b0111);
        tick(); chk("movz_wb", 32'(state), 4);
        chk("movz0_regwr", 32'(RegWr), 0);
        movz = 1'b1;
        #1;
        chk("movz1_regwr", 32'(RegWr), 1);
        tick(); chk("movz_if", 32'(state), 0);
        movz = 1'b0;

        // rotr and srl share funct 02
        Instr = 32'h00221142;
        tick(); tick();
        chk("rotr_aluctr", 32'(ALUCtr), 4'b1000);
        tick(); tick(); chk("rotr_if", 32'(state), 0);
        Instr = 32'h00011042;
        tick(); tick();
        chk("srl_aluctr", 32'(ALUCtr), 4'b0110);
        tick(); tick();

        // ori / lui immediate paths
        Instr = 32'h34210005;
        tick(); tick();
        chk("ori_aluctr", 32'(ALUCtr), 4'b0011);
        chk("ori_extop", 32'(ExtOp), 0);
        chk("ori_alusrc", 32'(ALUSrc), 1);
        tick(); chk("ori_regdst", 32'(RegDst), 0);
        tick();
        Instr = 32'h3C010001;
        tick(); tick();
        chk("lui_extop", 32'(ExtOp), 2);
        chk("lui_aluctr", 32'(ALUCtr), 4'b0000);
        tick(); tick();

        // jal
        Instr = 32'h0C000010;
        tick();
        chk("jal_dt", 32'(state), 1);
        chk("jal_pcwr", 32'(PCWr), 1);
        chk("jal_pcsrc", 32'(PCSrc), 2);
        chk("jal_regwr", 32'(RegWr), 1);
        chk("jal_regdst", 32'(RegDst), 2);
        chk("jal_memtoreg", 32'(MemtoReg), 2);
        tick(); chk("jal_if", 32'(state), 0);

        // j: no link write
        Instr = 32'h08000010;
        tick();
        chk("j_pcsrc", 32'(PCSrc), 2);
        chk("j_regwr", 32'(RegWr), 0);
        tick(); chk("j_if", 32'(state), 0);

        // jr $31
        Instr = 32'h03E00008;
        tick();
        chk("jr_pcwr", 32'(PCWr), 1);
        chk("jr_pcsrc", 32'(PCSrc), 3);
        tick(); chk("jr_if", 32'(state), 0);

        // undefined opcode behaves as NOP
        Instr = 32'hFC000000;
        tick();
        chk("nop_pcwr", 32'(PCWr), 0);
        chk("nop_regwr", 32'(RegWr), 0);
        tick(); chk("nop_if", 32'(state), 0);

        // sw: normal MEM write, then aborted by reset in MEM
        Instr = 32'hAC220008;
        tick(); tick();
        chk("sw_alusrc", 32'(ALUSrc), 1);
        chk("sw_extop", 32'(ExtOp), 1);
        tick(); chk("sw_mem", 32'(state), 3);
        chk("sw_memwr", 32'(MemWr), 1);
        chk("sw_regwr", 32'(RegWr), 0);
        tick(); chk("sw_if", 32'(state), 0);
        tick(); tick(); tick();
        chk("swab_mem", 32'(state), 3);
        reset = 1'b0;
        #1;
        chk("swab_memwr", 32'(MemWr), 0);
        tick(); chk("swab_state", 32'(state), 0);
        reset = 1'b1;
        #1;
        chk("swab_if_irwr", 32'(IRWr), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
